// File: rtl/iomem_rng_pkg.sv
// Shared constants and types for the iomem_rng random-word responder:
// register offsets, STATUS bit positions, default taps and the LFSR step rule.
package iomem_rng_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_SEED   = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int STAT_EMPTY_BIT     = 8;
    localparam int STAT_FULL_BIT      = 9;
    localparam int STAT_UNDERFLOW_BIT = 16;

    localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_RESET   = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_STALL = 2'd2
    } hs_state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v, input logic [31:0] taps);
        return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
    endfunction

endpackage

// File: rtl/iomem_rng_if.sv
// iomem_* bus bundle between the CPU external I/O port (master) and a target (slave).
interface iomem_rng_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/iomem_rng_fifo.sv
// Small synchronous word FIFO with flush; FIFO_DEPTH must be a power of two (2..16).
module iomem_rng_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [4:0]       level,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push_ok, pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];
    assign level   = 5'(count);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/iomem_rng.sv
// Memory-mapped random-word responder: window decode, CTRL/SEED/DATA/STATUS registers, Galois LFSR, iomem handshake.
// Define IOMEM_RNG_BLOCKING_EN to make DATA reads on an empty FIFO stall instead of returning 0 with underflow.
//
// state    | meaning
// ST_IDLE  | no transaction in flight; a window hit is acknowledged next cycle
// ST_ACK   | iomem_ready high for exactly this cycle
// ST_STALL | blocking DATA read waiting for the FIFO to receive a word
module iomem_rng
    import iomem_rng_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] LFSR_TAPS  = DEFAULT_TAPS
) (
    input logic        clk,
    input logic        resetn,
    iomem_rng_if.slave bus
);
`ifdef IOMEM_RNG_BLOCKING_EN
    localparam bit BLOCKING = 1'b1;
`else
    localparam bit BLOCKING = 1'b0;
`endif

    hs_state_t   state, state_nxt;
    logic        en, underflow;
    logic [31:0] lfsr, lfsr_nxt, lfsr_stepped, lfsr_base, seed_val;
    logic [31:0] rdata_q, rdata_nxt, rd_val, status_word;
    logic [4:0]  step_cnt, step_cnt_nxt, fifo_level;
    logic [31:0] fifo_dout;
    logic        fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic        hit, is_rd, data_rd, do_ack;
    logic        wr_ctrl, wr_seed, flush_req, reseed, step_en;
    logic [1:0]  reg_sel;
    logic        unused_addr_bits;

    assign hit     = bus.iomem_valid && (bus.iomem_addr[31:4] == BASE_ADDR[31:4]);
    assign is_rd   = (bus.iomem_wstrb == 4'b0000);
    assign reg_sel = bus.iomem_addr[3:2];
    assign data_rd = is_rd && (reg_sel == REG_DATA);
    assign unused_addr_bits = &{1'b0, bus.iomem_addr[1:0]};

    always_comb begin
        state_nxt = state;
        do_ack    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (hit) begin
                    if (BLOCKING && data_rd && fifo_empty) begin
                        state_nxt = ST_STALL;
                    end else begin
                        state_nxt = ST_ACK;
                        do_ack    = 1'b1;
                    end
                end
            end
            ST_ACK: state_nxt = ST_IDLE;
            ST_STALL: begin
                if (!(hit && data_rd)) begin
                    state_nxt = ST_IDLE;
                end else if (!fifo_empty) begin
                    state_nxt = ST_ACK;
                    do_ack    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign wr_ctrl   = do_ack && !is_rd && (reg_sel == REG_CTRL);
    assign wr_seed   = do_ack && !is_rd && (reg_sel == REG_SEED);
    assign flush_req = wr_ctrl && bus.iomem_wstrb[0] && bus.iomem_wdata[1];
    assign reseed    = wr_seed || flush_req;

    always_comb begin
        seed_val = lfsr;
        for (int b = 0; b < 4; b++) begin
            if (bus.iomem_wstrb[b]) seed_val[8*b +: 8] = bus.iomem_wdata[8*b +: 8];
        end
    end

    // The generator freezes while the FIFO is full so no word is ever lost.
    assign step_en      = en && !fifo_full;
    assign lfsr_stepped = lfsr_step(lfsr, LFSR_TAPS);
    assign lfsr_base    = wr_seed ? seed_val : lfsr;
    assign fifo_push    = step_en && (step_cnt == 5'd31) && !reseed;
    assign fifo_pop     = do_ack && data_rd && !fifo_empty;

    always_comb begin
        lfsr_nxt     = lfsr;
        step_cnt_nxt = step_cnt;
        if (reseed) begin
            lfsr_nxt     = (lfsr_base == '0) ? LFSR_RESET : lfsr_base;
            step_cnt_nxt = '0;
        end else if (step_en) begin
            lfsr_nxt     = lfsr_stepped;
            step_cnt_nxt = step_cnt + 1'b1;
        end
    end

    always_comb begin
        status_word                     = '0;
        status_word[4:0]                = fifo_level;
        status_word[STAT_EMPTY_BIT]     = fifo_empty;
        status_word[STAT_FULL_BIT]      = fifo_full;
        status_word[STAT_UNDERFLOW_BIT] = underflow;
    end

    always_comb begin
        rd_val = '0;
        unique case (reg_sel)
            REG_CTRL: rd_val = {31'd0, en};
            REG_SEED: rd_val = lfsr;
            REG_DATA: rd_val = fifo_empty ? '0 : fifo_dout;
            default:  rd_val = status_word;
        endcase
        rdata_nxt = (do_ack && is_rd) ? rd_val : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            rdata_q   <= '0;
            en        <= 1'b0;
            lfsr      <= LFSR_RESET;
            step_cnt  <= '0;
            underflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            rdata_q  <= rdata_nxt;
            lfsr     <= lfsr_nxt;
            step_cnt <= step_cnt_nxt;
            if (wr_ctrl && bus.iomem_wstrb[0]) en <= bus.iomem_wdata[0];
            // STATUS read returns the sticky flag and clears it on the same edge.
            if (do_ack && is_rd && (reg_sel == REG_STATUS)) underflow <= 1'b0;
            else if (do_ack && data_rd && fifo_empty)      underflow <= 1'b1;
        end
    end

    assign bus.iomem_ready = (state == ST_ACK);
    assign bus.iomem_rdata = rdata_q;

    iomem_rng_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (32)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .flush  (reseed),
        .din    (lfsr_stepped),
        .dout   (fifo_dout),
        .level  (fifo_level),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

endmodule

// File: tb/tb_iomem_rng.sv
// Bench for iomem_rng: directed register table, generator sequences and randomized bus traffic
// checked against a queue-based reference model.
module tb_iomem_rng;

    localparam logic [31:0] BASE  = 32'h0300_0000;
    localparam logic [31:0] TAPS  = 32'h8020_0003;
    localparam int          DEPTH = 4;
`ifdef IOMEM_RNG_BLOCKING_EN
    localparam bit BLOCKING = 1'b1;
`else
    localparam bit BLOCKING = 1'b0;
`endif

    logic clk;
    logic resetn;
    iomem_rng_if bus();

    iomem_rng dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] galois(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
    endfunction

    function automatic logic [31:0] galois_n(input logic [31:0] x0, input int n);
        logic [31:0] x = x0;
        for (int i = 0; i < n; i++) x = galois(x);
        return x;
    endfunction

    // Reference model: generator state, word queue and the transaction being offered.
    bit          m_en, m_uf, m_ack, m_ack_prev;
    logic [31:0] m_lfsr, m_rdata;
    int          m_cnt;
    logic [31:0] m_q[$];
    bit          t_go;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_strb;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_en = 0; m_uf = 0; m_ack = 0; m_ack_prev = 0;
            m_lfsr = 32'h1; m_cnt = 0; m_rdata = 0;
            m_q.delete();
        end else begin
            logic [31:0] stepped, merged, rv;
            bit          push, reseed, hit, rd;
            int          reg_i;
            stepped = m_lfsr; merged = m_lfsr; rv = 0; push = 0; reseed = 0;
            hit   = t_go && (t_addr[31:4] == BASE[31:4]);
            rd    = (t_strb == 4'd0);
            reg_i = int'(t_addr[3:2]);
            if (m_en && m_q.size() < DEPTH) begin
                stepped = galois(m_lfsr);
                m_cnt   = (m_cnt + 1) % 32;
                push    = (m_cnt == 0);
            end
            m_ack_prev = m_ack;
            m_ack      = 0;
            if (hit && !m_ack_prev && !(BLOCKING && rd && reg_i == 2 && m_q.size() == 0)) begin
                m_ack = 1;
                if (rd) begin
                    case (reg_i)
                        0: rv = {31'd0, m_en};
                        1: rv = m_lfsr;
                        2: if (m_q.size() > 0) rv = m_q.pop_front(); else m_uf = 1;
                        default: begin
                            rv = {15'd0, m_uf, 6'd0, m_q.size() == DEPTH, m_q.size() == 0, 3'd0, 5'(m_q.size())};
                            m_uf = 0;
                        end
                    endcase
                end else if (reg_i == 0 && t_strb[0]) begin
                    m_en   = t_wdata[0];
                    reseed = t_wdata[1];
                end else if (reg_i == 1) begin
                    for (int b = 0; b < 4; b++)
                        if (t_strb[b]) merged[8*b +: 8] = t_wdata[8*b +: 8];
                    reseed = 1;
                end
            end
            m_rdata = rv;
            if (reseed) begin
                m_q.delete();
                m_cnt  = 0;
                m_lfsr = (merged == 0) ? 32'h1 : merged;
            end else begin
                m_lfsr = stepped;
                if (push) m_q.push_back(stepped);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_op(input string name, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata, input int budget,
                          output bit acked, output logic [31:0] rd);
        acked = 0;
        rd    = 0;
        t_addr = addr; t_strb = strb; t_wdata = wdata; t_go = 1;
        bus.iomem_addr = addr; bus.iomem_wstrb = strb; bus.iomem_wdata = wdata; bus.iomem_valid = 1;
        for (int i = 0; i < budget && !acked; i++) begin
            @(posedge clk);
            #1;
            check({name, " ready"}, {31'd0, bus.iomem_ready}, {31'd0, m_ack});
            check({name, " rdata"}, bus.iomem_rdata, m_ack ? m_rdata : 32'd0);
            if (m_ack) begin
                acked = 1;
                rd    = bus.iomem_rdata;
            end
        end
        if (acked) begin
            // valid is still held here, as a real CPU would; ready must not repeat
            @(posedge clk);
            #1;
            check({name, " single ready"}, {31'd0, bus.iomem_ready}, 32'd0);
            t_go = 0; bus.iomem_valid = 0;
        end else begin
            t_go = 0; bus.iomem_valid = 0;
            idle(1);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp;
        bit          nb_only;
    } vec_t;

    vec_t tbl[18];

    initial begin
        bit          acked;
        logic [31:0] rd, r1;
        tbl[0]  = '{BASE + 32'hC, 4'h0, 32'h0,         32'h0000_0100, 1'b0};
        tbl[1]  = '{BASE + 32'h0, 4'h0, 32'h0,         32'h0000_0000, 1'b0};
        tbl[2]  = '{BASE + 32'h4, 4'h0, 32'h0,         32'h0000_0001, 1'b0};
        tbl[3]  = '{BASE + 32'h4, 4'hF, 32'h0,         32'h0000_0000, 1'b0};
        tbl[4]  = '{BASE + 32'h4, 4'h0, 32'h0,         32'h0000_0001, 1'b0};
        tbl[5]  = '{BASE + 32'h4, 4'h3, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[6]  = '{BASE + 32'h4, 4'h0, 32'h0,         32'h0000_BEEF, 1'b0};
        tbl[7]  = '{BASE + 32'h4, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b0};
        tbl[8]  = '{BASE + 32'h4, 4'hC, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
        tbl[9]  = '{BASE + 32'h4, 4'h0, 32'h0,         32'hAABB_5678, 1'b0};
        tbl[10] = '{BASE + 32'h8, 4'h0, 32'h0,         32'h0000_0000, 1'b1};
        tbl[11] = '{BASE + 32'hC, 4'h0, 32'h0,         32'h0001_0100, 1'b1};
        tbl[12] = '{BASE + 32'hC, 4'h0, 32'h0,         32'h0000_0100, 1'b0};
        tbl[13] = '{BASE + 32'h8, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[14] = '{BASE + 32'h0, 4'h1, 32'h0000_0002, 32'h0000_0000, 1'b0};
        tbl[15] = '{BASE + 32'h0, 4'h0, 32'h0,         32'h0000_0000, 1'b0};
        tbl[16] = '{BASE + 32'h4, 4'h0, 32'h0,         32'hAABB_5678, 1'b0};
        tbl[17] = '{BASE + 32'hC, 4'h0, 32'h0,         32'h0000_0100, 1'b0};

        t_go = 0; t_addr = 0; t_strb = 0; t_wdata = 0;
        bus.iomem_valid = 0; bus.iomem_addr = 0; bus.iomem_wstrb = 0; bus.iomem_wdata = 0;
        resetn = 0;
        #23;
        check("reset ready", {31'd0, bus.iomem_ready}, 32'd0);
        check("reset rdata", bus.iomem_rdata, 32'd0);
        resetn = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            if (!(BLOCKING && tbl[i].nb_only)) begin
                bus_op($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].strb, tbl[i].wdata, 4, acked, rd);
                check($sformatf("tbl%0d ack", i), {31'd0, acked}, 32'd1);
                check($sformatf("tbl%0d value", i), rd, tbl[i].exp);
            end
        end

        // First word after enabling from seed 1
        bus_op("seed1", BASE + 32'h4, 4'hF, 32'h1, 4, acked, rd);
        bus_op("en", BASE + 32'h0, 4'h1, 32'h1, 4, acked, rd);
        idle(33);
        bus_op("first word", BASE + 32'h8, 4'h0, 32'h0, 4, acked, rd);
        check("first word value", rd, galois_n(32'h1, 32));
        bus_op("level after pop", BASE + 32'hC, 4'h0, 32'h0, 4, acked, rd);

        // Fill until full, generator frozen, then drain four consecutive words
        idle(200);
        bus_op("full status", BASE + 32'hC, 4'h0, 32'h0, 4, acked, rd);
        check("full status value", rd, 32'h0000_0204);
        bus_op("frozen seed a", BASE + 32'h4, 4'h0, 32'h0, 4, acked, r1);
        idle(10);
        bus_op("frozen seed b", BASE + 32'h4, 4'h0, 32'h0, 4, acked, rd);
        check("frozen seed a value", r1, galois_n(32'h1, 160));
        check("frozen seed b value", rd, galois_n(32'h1, 160));
        for (int k = 2; k <= 5; k++) begin
            bus_op($sformatf("drain%0d", k), BASE + 32'h8, 4'h0, 32'h0, 4, acked, rd);
            check($sformatf("drain%0d value", k), rd, galois_n(32'h1, 32 * k));
        end

        // Reset while ready is high
        t_addr = BASE + 32'hC; t_strb = 0; t_go = 1;
        bus.iomem_addr = BASE + 32'hC; bus.iomem_wstrb = 0; bus.iomem_valid = 1;
        @(posedge clk);
        #1;
        check("pre-reset ready", {31'd0, bus.iomem_ready}, 32'd1);
        resetn = 0;
        #1;
        check("mid-reset ready", {31'd0, bus.iomem_ready}, 32'd0);
        check("mid-reset rdata", bus.iomem_rdata, 32'd0);
        t_go = 0; bus.iomem_valid = 0;
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;
        bus_op("post-reset status", BASE + 32'hC, 4'h0, 32'h0, 4, acked, rd);
        check("post-reset status value", rd, 32'h0000_0100);

        if (BLOCKING) begin
            bus_op("blk stall", BASE + 32'h8, 4'h0, 32'h0, 50, acked, rd);
            check("blk stall no ack", {31'd0, acked}, 32'd0);
            bus_op("blk en", BASE + 32'h0, 4'h1, 32'h1, 4, acked, rd);
            bus_op("blk wait", BASE + 32'h8, 4'h0, 32'h0, 45, acked, rd);
            check("blk wait ack", {31'd0, acked}, 32'd1);
            check("blk wait value", rd, galois_n(32'h1, 32));
        end

        // Out-of-window request must be ignored
        bus_op("miss", BASE ^ 32'h0010_0000, 4'h0, 32'h0, 3, acked, rd);
        check("miss no ack", {31'd0, acked}, 32'd0);

        for (int k = 0; k < 120; k++) begin
            int          sel, kind;
            logic [31:0] a, wd;
            logic [3:0]  st;
            kind = $urandom_range(0, 9);
            sel  = $urandom_range(0, 3);
            a    = BASE | (32'(sel) << 2) | 32'($urandom_range(0, 3));
            st   = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            wd   = $urandom;
            if (sel == 0) begin
                wd[0] = ($urandom_range(0, 3) != 0);
                wd[1] = ($urandom_range(0, 7) == 0);
            end
            if (BLOCKING && sel == 2 && st == 4'h0 && m_q.size() == 0) st = 4'h1;
            if (kind == 0) begin
                bus_op("rnd miss", a ^ 32'h0100_0000, st, wd, 3, acked, rd);
                check("rnd miss no ack", {31'd0, acked}, 32'd0);
            end else begin
                bus_op($sformatf("rnd%0d", k), a, st, wd, 4, acked, rd);
                check($sformatf("rnd%0d ack", k), {31'd0, acked}, 32'd1);
            end
            idle($urandom_range(0, 40));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
